// File: rtl/alu_cmd_driver.sv
// Initiator for the 8-bit combinational ALU: takes commands over valid/ready,
// drives the ALU inputs, captures the result after a settle window, returns it.
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_opa,
  input  logic [7:0]       cmd_opb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_op,
  output logic             rsp_err,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [7:0]       alu_opa,
  output logic [7:0]       alu_opb,
  output logic [3:0]       alu_mux,
  input  logic [7:0]       alu_result,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_OP   = 4'hB;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       pend_err;
  logic       pend_div0;
  logic [3:0] sweep_idx;
  logic [7:0] sweep_opa, sweep_opb;

  logic       take_cmd, take_sweep, retire, sweep_next, sweep_last, issue;
  logic [3:0] iss_op;
  logic [7:0] iss_opa, iss_opb;
  logic       iss_bad, iss_div0;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    cmd_ready  = 1'b0;
    state_nxt  = state;
    take_sweep = (state == IDLE) && !sweep_busy && sweep_start;
    if (rst_n && (state == IDLE) && !sweep_busy && !sweep_start)
      cmd_ready = 1'b1;
    take_cmd   = cmd_valid && cmd_ready;
    retire     = (state == RESP) && rsp_ready;
    sweep_next = retire && sweep_busy && (sweep_idx != LAST_OP);
    sweep_last = retire && sweep_busy && (sweep_idx == LAST_OP);
    issue      = take_cmd || take_sweep || sweep_next;

    iss_op  = cmd_op;
    iss_opa = cmd_opa;
    iss_opb = cmd_opb;
    if (take_sweep) begin
      iss_op = 4'h0;
    end else if (sweep_next) begin
      iss_op  = sweep_idx + 4'd1;
      iss_opa = sweep_opa;
      iss_opb = sweep_opb;
    end
    iss_div0 = (iss_op == 4'h3) && (iss_opb == 8'h00);
    iss_bad  = (iss_op > LAST_OP) || iss_div0;

    case (state)
      IDLE:    if (issue) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (retire) state_nxt = issue ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The settle window is one cycle for the ALU inputs to register plus
  // SETTLE_CYCLES; rejected commands use a zero-length window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      pend_err   <= 1'b0;
      pend_div0  <= 1'b0;
      alu_opa    <= '0;
      alu_opb    <= '0;
      alu_mux    <= '0;
      rsp_op     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (issue) begin
        rsp_op    <= iss_op;
        pend_err  <= iss_bad;
        pend_div0 <= iss_div0;
        if (iss_bad) begin
          settle_cnt <= 4'd0;
        end else begin
          settle_cnt <= SETTLE_LD;
          alu_opa    <= iss_opa;
          alu_opb    <= iss_opb;
          alu_mux    <= iss_op;
        end
      end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if ((state == SETTLE) && (settle_cnt == 4'd0)) begin
        rsp_err    <= pend_err;
        rsp_result <= pend_err ? (pend_div0 ? 8'hFF : 8'h00) : alu_result;
      end

      if (retire) op_count <= op_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      sweep_idx  <= '0;
      sweep_opa  <= '0;
      sweep_opb  <= '0;
    end else begin
      sweep_done <= sweep_last;
      if (take_sweep) begin
        sweep_busy <= 1'b1;
        sweep_idx  <= 4'h0;
        sweep_opa  <= cmd_opa;
        sweep_opb  <= cmd_opb;
      end else if (sweep_next) begin
        sweep_idx <= sweep_idx + 4'd1;
      end else if (sweep_last) begin
        sweep_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with an attached behavioural ALU and a
// scoreboard queue of expected responses.
module tb_alu_cmd_driver;

  localparam int S  = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [7:0]    cmd_opa, cmd_opb;
  logic          rsp_valid, rsp_ready;
  logic [7:0]    rsp_result;
  logic [3:0]    rsp_op;
  logic          rsp_err;
  logic          sweep_start, sweep_busy, sweep_done;
  logic [7:0]    alu_opa, alu_opb, alu_result;
  logic [3:0]    alu_mux;
  logic [CW-1:0] op_count;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count = '0;

  localparam logic [7:0] SWEEP_EXP [12] = '{8'hA5, 8'h2F, 8'h6E, 8'h01, 8'h95, 8'h2A,
                                            8'h7B, 8'hD5, 8'h84, 8'h51, 8'hD4, 8'h35};

  alu_cmd_driver #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_mux(alu_mux),
    .alu_result(alu_result), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide-by-zero returns 0 so the driver's 0xFF is visible.
  always_comb begin
    alu_result = 8'h00;
    case (alu_mux)
      4'h0: alu_result = alu_opa + alu_opb;
      4'h1: alu_result = alu_opa - alu_opb;
      4'h2: alu_result = 8'((16'(alu_opa) * 16'(alu_opb)) & 16'h00FF);
      4'h3: alu_result = (alu_opb == 8'h00) ? 8'h00 : alu_opa / alu_opb;
      4'h4: alu_result = ~alu_opa;
      4'h5: alu_result = alu_opa & alu_opb;
      4'h6: alu_result = alu_opa | alu_opb;
      4'h7: alu_result = ~(alu_opa & alu_opb);
      4'h8: alu_result = ~(alu_opa | alu_opb);
      4'h9: alu_result = alu_opa ^ alu_opb;
      4'hA: alu_result = {alu_opa[6:0], 1'b0};
      4'hB: alu_result = {1'b0, alu_opa[7:1]};
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] res, input logic err);
    exp_t e;
    e.op  = op;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 12; i++) push(4'(i), SWEEP_EXP[i], 1'b0);
  endtask

  // Leaves the caller 1 time unit after the accept edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_op    = op;
    cmd_opa   = a;
    cmd_opb   = b;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Latency is counted in edges from the issuing edge; hold > 0 applies back-pressure.
  task automatic get_rsp(input string tag, input int exp_lat, input int hold);
    int   lat = 0;
    exp_t e;
    while (!rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(rsp_result), 32'(e.res));
      check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, "_hold_count"}, 32'(op_count), 32'(exp_count));
    end
    check({tag, "_result"}, 32'(rsp_result), 32'(e.res));
    check({tag, "_op"}, 32'(rsp_op), 32'(e.op));
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check({tag, "_retired"}, 32'(rsp_valid), 32'd0);
    check({tag, "_count"}, 32'(op_count), 32'(exp_count));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
    check({tag, "_alu_opa"}, 32'(alu_opa), 32'd0);
    check({tag, "_alu_mux"}, 32'(alu_mux), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
    check({tag, "_sweep_busy"}, 32'(sweep_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_opa     = '0;
    cmd_opb     = '0;
    rsp_ready   = 1'b0;
    sweep_start = 1'b0;
    repeat (2) step();
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single add
    push(4'h0, 8'hA5, 1'b0);
    send(4'h0, 8'h6A, 8'h3B);
    check("add_alu_opa", 32'(alu_opa), 32'h6A);
    check("add_alu_mux", 32'(alu_mux), 32'h0);
    get_rsp("add", S + 1, 0);

    // Self-sweep
    cmd_opa     = 8'h6A;
    cmd_opb     = 8'h3B;
    sweep_start = 1'b1;
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    check("sweep_busy_set", 32'(sweep_busy), 32'd1);
    push_sweep();
    for (int i = 0; i < 12; i++) begin
      get_rsp("sweep", S + 1, 0);
      check("sweep_done", 32'(sweep_done), 32'(i == 11));
      check("sweep_busy", 32'(sweep_busy), 32'(i != 11));
    end
    step();
    check("sweep_done_pulse_end", 32'(sweep_done), 32'd0);

    // Back-pressure
    push(4'h5, 8'h30, 1'b0);
    send(4'h5, 8'hF0, 8'h3C);
    get_rsp("bp", S + 1, 5);

    // Illegal opcode and divide-by-zero leave the ALU inputs untouched
    push(4'hD, 8'h00, 1'b1);
    send(4'hD, 8'h11, 8'h22);
    get_rsp("illegal", 1, 0);
    check("illegal_alu_mux", 32'(alu_mux), 32'h5);
    check("illegal_alu_opa", 32'(alu_opa), 32'hF0);
    push(4'h3, 8'hFF, 1'b1);
    send(4'h3, 8'h40, 8'h00);
    get_rsp("div0", 1, 0);
    check("div0_alu_mux", 32'(alu_mux), 32'h5);
    check("div0_alu_opb", 32'(alu_opb), 32'h3C);
    push(4'h3, 8'h08, 1'b0);
    send(4'h3, 8'h40, 8'h08);
    get_rsp("div", S + 1, 0);
    check("div_alu_mux", 32'(alu_mux), 32'h3);

    // Reset during SETTLE
    send(4'h1, 8'h50, 8'h10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_settle");
    step();
    rst_n = 1'b1;
    sb.delete();
    exp_count = '0;
    step();
    check("rst_settle_no_rsp", 32'(rsp_valid), 32'd0);

    // Reset during RESP
    send(4'h2, 8'h07, 8'h03);
    for (int i = 0; i < 50 && !rsp_valid; i++) step();
    check("rst_resp_reached", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    step();
    rst_n = 1'b1;
    step();
    check("rst_resp_no_rsp", 32'(rsp_valid), 32'd0);

    push(4'h0, 8'h03, 1'b0);
    send(4'h0, 8'h01, 8'h02);
    get_rsp("post_rst", S + 1, 0);

    // Collision: sweep wins, the command waits for the sweep to finish
    cmd_op      = 4'h9;
    cmd_opa     = 8'h6A;
    cmd_opb     = 8'h3B;
    cmd_valid   = 1'b1;
    sweep_start = 1'b1;
    #1;
    check("coll_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    check("coll_sweep_busy", 32'(sweep_busy), 32'd1);
    push_sweep();
    for (int i = 0; i < 12; i++) get_rsp("coll_sweep", S + 1, 0);
    check("coll_cmd_ready_after", 32'(cmd_ready), 32'd1);
    push(4'h9, 8'h51, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    get_rsp("coll_cmd", S + 1, 0);

    // Counter wrap: 14 responses since reset, two more reach 16
    push(4'hA, 8'h02, 1'b0);
    send(4'hA, 8'h81, 8'h00);
    get_rsp("wrap_a", S + 1, 0);
    push(4'h8, 8'h00, 1'b0);
    send(4'h8, 8'hF0, 8'h0F);
    get_rsp("wrap_b", S + 1, 0);
    check("wrap_zero", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
